// File: rtl/cdm_pkg.sv
// Shared constants and helpers for the cdm_mul_pipe carry-disregard multiplier.
// Optional build macro used by the top: CDM_EXACT_BYPASS_EN.
package cdm_pkg;

    localparam int CDM_WIDTH = 16;
    localparam int CDM_H     = CDM_WIDTH / 2;
    localparam int CDM_MAX_H = 16;

    function automatic logic [63:0] cdm_low_mask(input int cols);
        if (cols <= 0) begin
            return '0;
        end
        if (cols >= 64) begin
            return '1;
        end
        return (64'd1 << cols) - 64'd1;
    endfunction

    localparam logic [63:0] CDM_SEG_MASK = cdm_low_mask(CDM_H);

    // One carry-free column: OR of every partial product a[i]&b[j-i] of weight 2^j.
    function automatic logic cdm_col_or(input logic [CDM_MAX_H-1:0] a,
                                        input logic [CDM_MAX_H-1:0] b,
                                        input int                   j);
        logic [2*CDM_MAX_H-1:0] row;
        logic                   r;
        r = 1'b0;
        for (int i = 0; i < CDM_MAX_H; i++) begin
            row = {{CDM_MAX_H{1'b0}}, b} << i;
            r = r | ((((a >> i) & CDM_MAX_H'(1)) != '0) &&
                     (((row >> j) & (2*CDM_MAX_H)'(1)) != '0));
        end
        return r;
    endfunction

endpackage

// File: rtl/cdm_lolo_mul.sv
// Combinational approximate H x H multiplier: low APPROX_COLS columns are carry-free ORs,
// the remaining columns are the exact sum of partial products of that weight and above.
module cdm_lolo_mul
    import cdm_pkg::*;
#(
    parameter int H           = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    localparam int P = 2 * H;
    localparam logic [P-1:0] HI_MASK = ~P'(cdm_low_mask(APPROX_COLS));

    logic [P-1:0] high_sum;
    logic [P-1:0] low_or;

    // Masking each shifted row drops only the partial products that fall in approximate columns.
    always_comb begin
        high_sum = '0;
        for (int i = 0; i < H; i++) begin
            if (((a >> i) & H'(1)) != '0) begin
                high_sum = high_sum + ((P'(b) << i) & HI_MASK);
            end
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_col
        if (j < APPROX_COLS) begin : g_or
            assign low_or[j] = cdm_col_or(CDM_MAX_H'(a), CDM_MAX_H'(b), j);
        end else begin : g_zero
            assign low_or[j] = 1'b0;
        end
    end

    assign p = high_sum | low_or;

endmodule

// File: rtl/cdm_mul_pipe.sv
// Three-stage carry-disregard approximate multiplier with valid/ready on both sides.
// Defining CDM_EXACT_BYPASS_EN adds a per-beat in_exact input that selects an exact product.
module cdm_mul_pipe
    import cdm_pkg::*;
#(
    parameter int WIDTH       = CDM_WIDTH,
    parameter int APPROX_COLS = 8,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef CDM_EXACT_BYPASS_EN
    input  logic                 in_exact,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_r,
    output logic [TAG_W-1:0]     out_tag,
    output logic [15:0]          op_cnt
);

    localparam int H  = WIDTH / 2;
    localparam int P  = 2 * H;
    localparam int SW = H + 2;

    typedef struct packed {
        logic             valid;
`ifdef CDM_EXACT_BYPASS_EN
        logic             exact;
`endif
        logic [TAG_W-1:0] tag;
        logic [P-1:0]     ll;
        logic [P-1:0]     hl;
        logic [P-1:0]     lh;
        logic [P-1:0]     hh;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [H-1:0]     hh_hi;
        logic [H-1:0]     seg2;
        logic [H-1:0]     seg1;
        logic [H-1:0]     ll_lo;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic         en;
    logic [H-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [P-1:0] ll_approx;
    logic [SW-1:0] sum1, sum2;
    logic [1:0]   c1, c2;
    logic         exact_mode;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    assign a_lo = in_a[H-1:0];
    assign a_hi = in_a[WIDTH-1:H];
    assign b_lo = in_b[H-1:0];
    assign b_hi = in_b[WIDTH-1:H];

    cdm_lolo_mul #(
        .H           (H),
        .APPROX_COLS (APPROX_COLS)
    ) u_lolo (
        .a (a_lo),
        .b (b_lo),
        .p (ll_approx)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.tag   = in_tag;
        s1_d.ll    = ll_approx;
`ifdef CDM_EXACT_BYPASS_EN
        s1_d.exact = in_exact;
        if (in_exact) begin
            s1_d.ll = P'(a_lo) * P'(b_lo);
        end
`endif
        s1_d.hl    = P'(a_hi) * P'(b_lo);
        s1_d.lh    = P'(a_lo) * P'(b_hi);
        s1_d.hh    = P'(a_hi) * P'(b_hi);
    end

`ifdef CDM_EXACT_BYPASS_EN
    assign exact_mode = s1_q.exact;
`else
    assign exact_mode = 1'b0;
`endif

    // Segment carries only ripple upward for exact beats; approximate beats wrap each segment.
    always_comb begin
        sum1 = SW'(s1_q.ll[P-1:H]) + SW'(s1_q.hl[H-1:0]) + SW'(s1_q.lh[H-1:0]);
        c1   = exact_mode ? sum1[SW-1:H] : 2'b00;
        sum2 = SW'(s1_q.hl[P-1:H]) + SW'(s1_q.lh[P-1:H]) + SW'(s1_q.hh[H-1:0]) + SW'(c1);
        c2   = exact_mode ? sum2[SW-1:H] : 2'b00;

        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.tag   = s1_q.tag;
        s2_d.ll_lo = s1_q.ll[H-1:0];
        s2_d.seg1  = sum1[H-1:0];
        s2_d.seg2  = sum2[H-1:0];
        s2_d.hh_hi = s1_q.hh[P-1:H] + H'(c2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
            op_cnt    <= '0;
        end else begin
            if (in_valid && in_ready) begin
                op_cnt <= op_cnt + 16'd1;
            end
            if (en) begin
                s1_q      <= s1_d;
                s2_q      <= s2_d;
                out_valid <= s2_q.valid;
                out_r     <= {s2_q.hh_hi, s2_q.seg2, s2_q.seg1, s2_q.ll_lo};
                out_tag   <= s2_q.tag;
            end
        end
    end

endmodule

// File: tb/tb_cdm_mul_pipe.sv
// Directed bench for cdm_mul_pipe (WIDTH=16, APPROX_COLS=8); exercises CDM_EXACT_BYPASS_EN when defined.
module tb_cdm_mul_pipe;

    localparam int WIDTH       = 16;
    localparam int APPROX_COLS = 8;
    localparam int TAG_W       = 4;
    localparam int NVEC        = 14;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic [TAG_W-1:0]    in_tag;
`ifdef CDM_EXACT_BYPASS_EN
    logic                in_exact;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  out_r;
    logic [TAG_W-1:0]    out_tag;
    logic [15:0]         op_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [NVEC];

    cdm_mul_pipe #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS),
        .TAG_W       (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
`ifdef CDM_EXACT_BYPASS_EN
        .in_exact  (in_exact),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] tag);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   lat;
        int   sent;
        int   got;
        logic acc;
        logic stalled_prev;
        logic [31:0] held_r;
        logic [3:0]  held_tag;

        vecs[0]  = '{16'h00FF, 16'h00FF, 32'h0000F7FF};
        vecs[1]  = '{16'hFF00, 16'h00FF, 32'h00FE0100};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 32'hFEFDF9FF};
        vecs[3]  = '{16'h0000, 16'h1234, 32'h00000000};
        vecs[4]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[5]  = '{16'h0003, 16'h0003, 32'h00000007};
        vecs[6]  = '{16'h0100, 16'h0100, 32'h00010000};
        vecs[7]  = '{16'h0080, 16'h0080, 32'h00004000};
        vecs[8]  = '{16'h1234, 16'h0001, 32'h00001234};
        vecs[9]  = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[10] = '{16'h01FF, 16'h01FF, 32'h0001F5FF};
        vecs[11] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[12] = '{16'h000F, 16'h000F, 32'h0000007F};
        vecs[13] = '{16'h00FF, 16'h0003, 32'h000001FF};

`ifdef CDM_EXACT_BYPASS_EN
        in_exact = 1'b0;
`endif
        doReset();
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_r", out_r, 32'd0);
        checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
        checkOutput("reset_op_cnt", 32'(op_cnt), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // One beat at a time: result, tag and accept-to-valid latency.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, 4'(i));
            @(posedge clk);
            @(negedge clk);
            applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            checkOutput($sformatf("vec%0d_out_r", i), out_r, vecs[i].r);
            checkOutput($sformatf("vec%0d_out_tag", i), 32'(out_tag), 32'(i));
            if (i == 0) begin
                checkOutput("vec0_op_cnt", 32'(op_cnt), 32'd1);
            end
        end
        @(negedge clk);
        checkOutput("table_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("table_op_cnt", 32'(op_cnt), 32'(NVEC));

        // Ten back-to-back beats with the consumer stalled in cycles 4..7.
        doReset();
        sent = 0;
        got = 0;
        stalled_prev = 1'b0;
        held_r = '0;
        held_tag = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            if (stalled_prev) begin
                checkOutput("stall_held_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_held_r", out_r, held_r);
                checkOutput("stall_held_tag", 32'(out_tag), 32'(held_tag));
            end
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 10) begin
                applyStimulus(1'b1, vecs[sent].a, vecs[sent].b, 4'(sent));
            end else begin
                applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
            end
            #1;
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                stalled_prev = 1'b1;
                held_r = out_r;
                held_tag = out_tag;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream%0d_out_r", got), out_r, vecs[got].r);
                checkOutput($sformatf("stream%0d_out_tag", got), 32'(out_tag), 32'(got));
                got++;
            end
            @(posedge clk);
            if (acc) begin
                sent++;
            end
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
        out_ready = 1'b1;
        checkOutput("stream_results", 32'(got), 32'd10);
        repeat (4) begin
            @(negedge clk);
            checkOutput("stream_no_extra", 32'(out_valid), 32'd0);
        end
        checkOutput("stream_op_cnt", 32'(op_cnt), 32'd10);

        // Reset with three beats in flight drops them all.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, vecs[k].a, vecs[k].b, 4'(k));
            @(posedge clk);
            @(negedge clk);
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
        checkOutput("flight_op_cnt", 32'(op_cnt), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_op_cnt", 32'(op_cnt), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("midrst_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef CDM_EXACT_BYPASS_EN
        // Exact bypass beat: full carries restore the true product.
        in_exact = 1'b1;
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 4'hA);
        @(posedge clk);
        @(negedge clk);
        in_exact = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("exact_latency", 32'(lat), 32'd3);
        checkOutput("exact_out_r", out_r, 32'hFFFE0001);
        checkOutput("exact_out_tag", 32'(out_tag), 32'hA);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
